// File: rtl/jtag_gpio_bridge.sv
// JTAG TAP bridging scan registers to parallel GPIO channels.
// All JTAG pins are oversampled and processed in the sys_clk domain.
module jtag_gpio_bridge #(
  parameter int          CHANNELS = 3,
  parameter int          WIDTH    = 8,
  parameter logic [31:0] IDCODE   = 32'h0F1E_A001,
  parameter int          IR_W     = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      jtag_tck,
  input  logic                      jtag_tms,
  input  logic                      jtag_tdi,
  output logic                      jtag_tdo,
  output logic                      jtag_tdo_en,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_strobe,
  input  logic [CHANNELS*WIDTH-1:0] in_data
);

  localparam int CW   = CHANNELS * WIDTH;
  localparam int DR_W = (CW > 32) ? CW : 32;
  localparam int AW   = $clog2(DR_W);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR,
    PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR,
    PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;
  logic       tck_rise;
  logic       tck_fall;
  logic       tms_s;
  logic       tdi_s;

  tap_e state_q;
  tap_e state_d;

  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] ir_sr;
  logic [DR_W-1:0] dr_q;
  logic [DR_W-1:0] dr_cap;
  logic [DR_W-1:0] dr_nxt;
  logic [AW-1:0]   dr_msb;
  logic            is_id;
  logic            is_out;
  logic            is_in;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
    end else begin
      tck_q <= {tck_q[1:0], jtag_tck};
      tms_q <= {tms_q[0], jtag_tms};
      tdi_q <= {tdi_q[0], jtag_tdi};
    end
  end

  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms_s    = tms_q[1];
  assign tdi_s    = tdi_q[1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= TLR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        TLR:    state_d = tms_s ? TLR    : RTI;
        RTI:    state_d = tms_s ? SEL_DR : RTI;
        SEL_DR: state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR: state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:  state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR: state_d = tms_s ? UPD_DR : PAU_DR;
        PAU_DR: state_d = tms_s ? EX2_DR : PAU_DR;
        EX2_DR: state_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR: state_d = tms_s ? SEL_DR : RTI;
        SEL_IR: state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR: state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:  state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR: state_d = tms_s ? UPD_IR : PAU_IR;
        PAU_IR: state_d = tms_s ? EX2_IR : PAU_IR;
        EX2_IR: state_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR: state_d = tms_s ? SEL_DR : RTI;
      endcase
    end
  end

  assign is_id  = (ir_q == IR_W'(1));
  assign is_out = (ir_q == IR_W'(2));
  assign is_in  = (ir_q == IR_W'(3));

  // One shared DR; TDI enters at the MSB of the selected length.
  always_comb begin
    dr_cap = '0;
    dr_msb = '0;
    unique case (1'b1)
      is_id: begin
        dr_cap = DR_W'(IDCODE);
        dr_msb = AW'(31);
      end
      is_out: begin
        dr_cap = DR_W'(out_data);
        dr_msb = AW'(CW - 1);
      end
      is_in: begin
        dr_cap = DR_W'(in_data);
        dr_msb = AW'(CW - 1);
      end
      default: ;
    endcase
    dr_nxt         = {1'b0, dr_q[DR_W-1:1]};
    dr_nxt[dr_msb] = tdi_s;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ir_q        <= IR_W'(1);
      ir_sr       <= '0;
      dr_q        <= '0;
      out_data    <= '0;
      out_strobe  <= 1'b0;
      jtag_tdo    <= 1'b0;
      jtag_tdo_en <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (tck_rise) begin
        if (state_q == SH_IR) ir_sr <= {tdi_s, ir_sr[IR_W-1:1]};
        if (state_q == SH_DR) dr_q <= dr_nxt;
        if (state_d == CAP_IR) ir_sr <= IR_W'(1);
        if (state_d == CAP_DR) dr_q <= dr_cap;
        if (state_d == UPD_IR) ir_q <= ir_sr;
        if (state_d == TLR) ir_q <= IR_W'(1);
        if (state_d == UPD_DR && is_out) begin
          out_data   <= dr_q[CW-1:0];
          out_strobe <= 1'b1;
        end
      end else if (tck_fall) begin
        if (state_q == SH_IR) begin
          jtag_tdo    <= ir_sr[0];
          jtag_tdo_en <= 1'b1;
        end else if (state_q == SH_DR) begin
          jtag_tdo    <= dr_q[0];
          jtag_tdo_en <= 1'b1;
        end else begin
          jtag_tdo    <= 1'b0;
          jtag_tdo_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_gpio_bridge.sv
// Bench for jtag_gpio_bridge: bit-banged TAP driven against
// a transaction-level model of the scan registers.
`timescale 1ns/1ps
module tb_jtag_gpio_bridge;

  localparam int          CH   = 3;
  localparam int          W    = 8;
  localparam int          CW   = CH * W;
  localparam int          IR_W = 4;
  localparam logic [31:0] IDC  = 32'h0F1E_A001;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          tck = 1'b0;
  logic          tms = 1'b1;
  logic          tdi = 1'b0;
  logic          tdo;
  logic          tdo_en;
  logic [CW-1:0] out_data;
  logic          out_strobe;
  logic [CW-1:0] in_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;

  logic [CW-1:0] m_out;

  jtag_gpio_bridge #(
    .CHANNELS(CH), .WIDTH(W), .IDCODE(IDC), .IR_W(IR_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .jtag_tck(tck), .jtag_tms(tms), .jtag_tdi(tdi),
    .jtag_tdo(tdo), .jtag_tdo_en(tdo_en),
    .out_data(out_data), .out_strobe(out_strobe),
    .in_data(in_data)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (out_strobe) strobes++;

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag,
                          input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One TCK period: low phase (TDO sampled at its end), then high.
  task automatic jclk(input logic t, input logic d,
                      output logic q, output logic e);
    tms = t;
    tdi = d;
    tck = 1'b0;
    repeat (4) @(negedge sys_clk);
    q = tdo;
    e = tdo_en;
    tck = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic jmove(input logic t);
    logic q, e;
    jclk(t, 1'b0, q, e);
  endtask

  task automatic shift_ir(input logic [IR_W-1:0] v,
                          output logic [IR_W-1:0] q);
    logic b, e;
    q = '0;
    jmove(1); jmove(1); jmove(0); jmove(0);
    for (int i = 0; i < IR_W; i++) begin
      jclk(i == IR_W - 1, v[i], b, e);
      q[i] = b;
    end
    jmove(1); jmove(0);
  endtask

  task automatic shift_dr(input int n, input logic [63:0] d,
                          output logic [63:0] q, output logic en_ok);
    logic b, e;
    q = '0;
    en_ok = 1'b1;
    jmove(1); jmove(0); jmove(0);
    for (int i = 0; i < n; i++) begin
      jclk(i == n - 1, d[i], b, e);
      q[i] = b;
      if (!e) en_ok = 1'b0;
    end
    jmove(1); jmove(0);
  endtask

  task automatic read_idcode(input string tag);
    logic [63:0] q;
    logic ok;
    shift_dr(32, {$urandom, $urandom}, q, ok);
    check_eq(tag, q[31:0], IDC);
    check_eq("tdo_en_shift", ok, 1'b1);
    check_eq("tdo_en_idle", tdo_en, 1'b0);
  endtask

  initial begin
    logic [IR_W-1:0] irq;
    logic [63:0]     q;
    logic [63:0]     d;
    logic            ok;
    logic            b, e;
    int              s0;
    int              n;
    int              code;

    m_out = '0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_tdo_en", tdo_en, 1'b0);
    check_eq("rst_strobe", out_strobe, 1'b0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    jmove(0);
    read_idcode("idcode_after_reset");

    shift_ir(IR_W'(2), irq);
    check_eq("ir_capture", irq, 4'b0001);
    s0 = strobes;
    shift_dr(CW, 64'hC3A55A, q, ok);
    check_eq("write_tdo_prev", q[CW-1:0], m_out);
    m_out = 24'hC3A55A;
    check_eq("write_out", out_data, m_out);
    check_eq("write_strobe", strobes - s0, 1);

    for (int k = 0; k < 4; k++) begin
      d = 64'($urandom_range(0, (1 << CW) - 1));
      s0 = strobes;
      shift_dr(CW, d, q, ok);
      check_eq("rnd_write_tdo", q[CW-1:0], m_out);
      m_out = d[CW-1:0];
      check_eq("rnd_write_out", out_data, m_out);
      check_eq("rnd_write_strobe", strobes - s0, 1);
    end

    in_data = 24'h123456;
    shift_ir(IR_W'(3), irq);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) in_data = CW'($urandom);
      s0 = strobes;
      shift_dr(CW, {$urandom, $urandom}, q, ok);
      check_eq("read_tdo", q[CW-1:0], in_data);
      check_eq("read_out_held", out_data, m_out);
      check_eq("read_no_strobe", strobes - s0, 0);
    end

    shift_ir(4'hF, irq);
    check_eq("bypass_ir_capture", irq, 4'b0001);
    shift_dr(4, 64'b1101, q, ok);
    check_eq("bypass_fixed", q[3:0], 4'b1010);
    for (int k = 0; k < 3; k++) begin
      do code = $urandom_range(0, 15);
      while (code >= 1 && code <= 3);
      shift_ir(IR_W'(code), irq);
      n = $urandom_range(2, 16);
      d = 64'($urandom);
      s0 = strobes;
      shift_dr(n, d, q, ok);
      check_eq("bypass_rnd",
               q & ((64'd1 << n) - 1),
               (d << 1) & ((64'd1 << n) - 1));
      check_eq("bypass_no_strobe", strobes - s0, 0);
    end

    // TMS reset out of Shift-IR: Update-DR never visited.
    shift_ir(IR_W'(2), irq);
    jmove(1); jmove(1); jmove(0); jmove(0);
    jmove(0); jmove(0);
    s0 = strobes;
    repeat (5) jmove(1);
    check_eq("tmsrst_ir_no_strobe", strobes - s0, 0);
    check_eq("tmsrst_ir_out_held", out_data, m_out);
    jmove(0);
    read_idcode("tmsrst_ir_idcode");

    // TMS reset out of Shift-DR with OUT_WRITE, DR refilled with m_out.
    shift_ir(IR_W'(2), irq);
    jmove(1); jmove(0); jmove(0);
    q = '0;
    for (int i = 0; i < CW; i++) begin
      jclk(i == CW - 1, m_out[i], b, e);
      q[i] = b;
    end
    repeat (4) jmove(1);
    check_eq("tmsrst_dr_tdo", q[CW-1:0], m_out);
    check_eq("tmsrst_dr_out_held", out_data, m_out);
    jmove(0);
    read_idcode("tmsrst_dr_idcode");

    // Reset asserted in the middle of an OUT_WRITE shift.
    shift_ir(IR_W'(2), irq);
    jmove(1); jmove(0); jmove(0);
    for (int i = 0; i < 10; i++) jclk(1'b0, 1'($urandom), b, e);
    s0 = strobes;
    sys_rst = 1'b1;
    #1;
    check_eq("abort_out_clear", out_data, '0);
    check_eq("abort_tdo_en", tdo_en, 1'b0);
    tck = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    m_out = '0;
    repeat (3) @(negedge sys_clk);
    check_eq("abort_no_strobe", strobes - s0, 0);
    jmove(0);
    read_idcode("abort_idcode");
    check_eq("abort_out_after", out_data, m_out);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
